alu_issue_ctrl: RTL

// Initiator side of the ALU operation interface. Accepts operation commands (op, A, B, tag) over valid/ready.

---
 rtl/alu_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the ALU operation interface. Commands (op, A, B, tag) are
// accepted over valid/ready, presented to a fixed-latency ALU datapath, and
// each returned result and flag set is re-associated with its tag and queued
// in an in-order response FIFO. Credit-based admission means a response always
// has a FIFO slot, so nothing is ever dropped. A flush FSM stops admission and
// waits for all outstanding traffic to drain.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_op_i, cmd_a_i, cmd_b_i   opcode and operands
//   cmd_tag_i                    opaque tag echoed with the response
//   alu_valid_o                  operation presented to the ALU this cycle
//   A_o, B_o, ALUControl_o       registered ALU operands and opcode
//   alu_valid_i, Result_i        ALU result return (ALU_LAT after alu_valid_o)
//   Z_i, C_i, N_i, OF_i          ALU flags
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_result_o, rsp_flags_o    result and flags {OF,N,C,Z}
//   rsp_tag_o                    tag of the originating command
//   flush_i                      drain request (level)
//   flush_done_o                 one-cycle pulse when the drain completes
//   err_o                        sticky: ALU return disagreed with expected slot
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ALU_LAT   = 2,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TAGW      = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [3:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    input  logic [TAGW-1:0]  cmd_tag_i,
    output logic             alu_valid_o,
    output logic [WIDTH-1:0] A_o,
    output logic [WIDTH-1:0] B_o,
    output logic [3:0]       ALUControl_o,
    input  logic             alu_valid_i,
    input  logic [WIDTH-1:0] Result_i,
    input  logic             Z_i,
    input  logic             C_i,
    input  logic             N_i,
    input  logic             OF_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic [3:0]       rsp_flags_o,
    output logic [TAGW-1:0]  rsp_tag_o,
    input  logic             flush_i,
    output logic             flush_done_o,
    output logic             err_o
);

    localparam int unsigned PTRW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;
        logic [TAGW-1:0]  tag;
    } rsp_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              ready_nxt;
    logic              done_nxt;

    logic              accept;
    logic [TAGW-1:0]   issue_tag;
    logic              exp_valid;
    logic [TAGW-1:0]   exp_tag;

    logic              wr_en;
    logic              rd_en;
    logic [PTRW-1:0]   wr_ptr;
    logic [PTRW-1:0]   rd_ptr;
    logic [CNTW-1:0]   count;
    logic [CNTW-1:0]   count_nxt;
    logic [CNTW-1:0]   inflight;
    logic [CNTW-1:0]   inflight_nxt;
    logic [CNTW-1:0]   credits_nxt;
    rsp_t              mem [RSP_DEPTH];
    rsp_t              head;

    assign accept = cmd_valid_i && cmd_ready_o;

    // Issue register: operands hold their last value when nothing is accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_valid_o  <= 1'b0;
            A_o          <= '0;
            B_o          <= '0;
            ALUControl_o <= '0;
            issue_tag    <= '0;
        end else begin
            alu_valid_o <= accept;
            if (accept) begin
                A_o          <= cmd_a_i;
                B_o          <= cmd_b_i;
                ALUControl_o <= cmd_op_i;
                issue_tag    <= cmd_tag_i;
            end
        end
    end

    // Expected-return tracker: valid/tag delayed by the ALU latency
    if (ALU_LAT == 0) begin : g_comb_alu
        assign exp_valid = alu_valid_o;
        assign exp_tag   = issue_tag;
    end else begin : g_pipe_alu
        logic [ALU_LAT-1:0] vld_sr;
        logic [TAGW-1:0]    tag_sr [ALU_LAT];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_sr <= '0;
                for (int i = 0; i < int'(ALU_LAT); i++) begin
                    tag_sr[i] <= '0;
                end
            end else begin
                vld_sr[0] <= alu_valid_o;
                tag_sr[0] <= issue_tag;
                for (int i = 1; i < int'(ALU_LAT); i++) begin
                    vld_sr[i] <= vld_sr[i-1];
                    tag_sr[i] <= tag_sr[i-1];
                end
            end
        end

        assign exp_valid = vld_sr[ALU_LAT-1];
        assign exp_tag   = tag_sr[ALU_LAT-1];
    end

    // Occupancy bookkeeping; the write slot is trusted even if alu_valid_i lies
    always_comb begin
        wr_en        = exp_valid;
        rd_en        = rsp_valid_o && rsp_ready_i;
        count_nxt    = count + CNTW'(wr_en) - CNTW'(rd_en);
        inflight_nxt = inflight + CNTW'(accept) - CNTW'(wr_en);
        credits_nxt  = CNTW'(RSP_DEPTH) - inflight_nxt - count_nxt;
    end

    // Response FIFO storage and pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            count    <= count_nxt;
            inflight <= inflight_nxt;
            if (wr_en) begin
                mem[wr_ptr] <= '{result: Result_i,
                                 flags:  {OF_i, N_i, C_i, Z_i},
                                 tag:    exp_tag};
                wr_ptr      <= wr_ptr + PTRW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
        end
    end

    assign head         = mem[rd_ptr];
    assign rsp_result_o = head.result;
    assign rsp_flags_o  = head.flags;
    assign rsp_tag_o    = head.tag;

    // Flush FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of the registered control outputs
    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_RUN: begin
                if (flush_i) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((inflight == '0) && (count == '0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!flush_i) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
        ready_nxt = (state_nxt == S_RUN) && (credits_nxt != '0);
        done_nxt  = (state_nxt == S_DONE) && (state != S_DONE);
    end

    // Registered control outputs; error is sticky until reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            flush_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            cmd_ready_o  <= ready_nxt;
            rsp_valid_o  <= (count_nxt != '0);
            flush_done_o <= done_nxt;
            if (alu_valid_i != exp_valid) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
